// File: rtl/netlist_vector_sequencer_if.sv
// ----------------------------------------------------------------------------
// netlist_vector_sequencer_if
// Run-control and netlist-facing signal bundle for the vector sequencer.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface netlist_vector_sequencer_if #(
    parameter int VEC_W = 42,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_vec;
    logic [VEC_W-1:0] seed;
    logic [VEC_W-1:0] dut_in;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] ones_cnt;
    logic [15:0]      signature;

    // master = run control plus the netlist under test; slave = the sequencer
    modport master (
        output start, abort, num_vec, seed, dut_out,
        input  dut_in, busy, done, vec_cnt, ones_cnt, signature
    );

    modport slave (
        input  start, abort, num_vec, seed, dut_out,
        output dut_in, busy, done, vec_cnt, ones_cnt, signature
    );
endinterface

`default_nettype wire

// File: rtl/netlist_vector_sequencer.sv
// ----------------------------------------------------------------------------
// netlist_vector_sequencer
// LFSR vector source for a 42-in/1-out netlist with settle timing, MISR and ones count.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module netlist_vector_sequencer #(
    parameter int VEC_W      = 42,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    netlist_vector_sequencer_if.slave bus
);
    localparam int              SC_W        = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [SC_W-1:0] SETTLE_INIT = SC_W'(SETTLE_CYC);
    localparam logic [15:0]     MISR_POLY   = 16'h1021;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e           state_q,    state_d;
    logic [VEC_W-1:0] lfsr_q,     lfsr_d;
    logic [VEC_W-1:0] dut_in_q,   dut_in_d;
    logic [CNT_W-1:0] num_vec_q,  num_vec_d;
    logic [CNT_W-1:0] vec_cnt_q,  vec_cnt_d;
    logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
    logic [15:0]      sig_q,      sig_d;
    logic [SC_W-1:0]  settle_q,   settle_d;
    logic             done_q,     done_d;

    logic [VEC_W-1:0] seed_eff;
    logic [VEC_W-1:0] lfsr_next;
    logic [CNT_W-1:0] vec_cnt_inc;
    logic [15:0]      sig_next;

    // Fibonacci taps 42,41,20,19 give a maximal-length sequence
    assign lfsr_next   = {lfsr_q[VEC_W-2:0],
                          lfsr_q[VEC_W-1] ^ lfsr_q[VEC_W-2] ^ lfsr_q[19] ^ lfsr_q[18]};
    assign seed_eff    = (bus.seed == '0) ? VEC_W'(1) : bus.seed;
    assign vec_cnt_inc = vec_cnt_q + CNT_W'(1);
    assign sig_next    = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000)
                       ^ {15'b0, bus.dut_out};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q     <= '0;
            dut_in_q   <= '0;
            num_vec_q  <= '0;
            vec_cnt_q  <= '0;
            ones_cnt_q <= '0;
            sig_q      <= '0;
            settle_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            dut_in_q   <= dut_in_d;
            num_vec_q  <= num_vec_d;
            vec_cnt_q  <= vec_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            sig_q      <= sig_d;
            settle_q   <= settle_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        dut_in_d   = dut_in_q;
        num_vec_d  = num_vec_q;
        vec_cnt_d  = vec_cnt_q;
        ones_cnt_d = ones_cnt_q;
        sig_d      = sig_q;
        settle_d   = settle_q;
        done_d     = 1'b0;

        if (state_q == ST_IDLE) begin
            // abort alongside start suppresses acceptance
            if (bus.start && !bus.abort) begin
                vec_cnt_d  = '0;
                ones_cnt_d = '0;
                sig_d      = '0;
                if (bus.num_vec != '0) begin
                    dut_in_d  = seed_eff;
                    lfsr_d    = seed_eff;
                    num_vec_d = bus.num_vec;
                    settle_d  = SETTLE_INIT;
                    state_d   = ST_SETTLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
        end else if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    settle_d = settle_q - SC_W'(1);
                    if (settle_q == SC_W'(1)) begin
                        state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    sig_d     = sig_next;
                    vec_cnt_d = vec_cnt_inc;
                    if (bus.dut_out && (ones_cnt_q != '1)) begin
                        ones_cnt_d = ones_cnt_q + CNT_W'(1);
                    end
                    if (vec_cnt_inc == num_vec_q) begin
                        state_d = ST_DONE;
                    end else begin
                        lfsr_d   = lfsr_next;
                        dut_in_d = lfsr_next;
                        settle_d = SETTLE_INIT;
                        state_d  = ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dut_in    = dut_in_q;
    assign bus.busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign bus.done      = done_q;
    assign bus.vec_cnt   = vec_cnt_q;
    assign bus.ones_cnt  = ones_cnt_q;
    assign bus.signature = sig_q;
endmodule

`default_nettype wire

// File: tb/tb_netlist_vector_sequencer.sv
// ----------------------------------------------------------------------------
// tb_netlist_vector_sequencer
// Scoreboard bench: expected run results queued at start, checked on done.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_netlist_vector_sequencer;
    localparam int VEC_W  = 42;
    localparam int CNT_W  = 16;
    localparam int SETTLE = 2;

    typedef struct {
        logic [15:0] vc;
        logic [15:0] ones;
        logic [15:0] sig;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic use_fn;
    logic const_out;
    exp_t sb_q[$];

    netlist_vector_sequencer_if #(.VEC_W(VEC_W), .CNT_W(CNT_W)) ifc ();

    netlist_vector_sequencer #(.VEC_W(VEC_W), .SETTLE_CYC(SETTLE), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the netlist: arbitrary nonlinear function of the vector
    function automatic logic netlist_fn(input logic [41:0] v);
        return (^(v & 42'h2A55A5AC3C3)) ^ (v[3] & v[17]) ^ (v[40] | v[0]);
    endfunction

    assign ifc.dut_out = use_fn ? netlist_fn(ifc.dut_in) : const_out;

    function automatic logic [41:0] lfsr_step(input logic [41:0] l);
        return {l[40:0], l[41] ^ l[40] ^ l[19] ^ l[18]};
    endfunction

    function automatic exp_t model_run(input logic [41:0] seed, input int n, input int start_edge);
        exp_t        e;
        logic [41:0] l;
        logic        b;
        l = (seed == '0) ? 42'd1 : seed;
        e.vc = '0; e.ones = '0; e.sig = '0;
        for (int i = 0; i < n; i++) begin
            b = use_fn ? netlist_fn(l) : const_out;
            e.sig = {e.sig[14:0], 1'b0} ^ (e.sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
            if (b && e.ones != 16'hFFFF) e.ones = e.ones + 16'd1;
            e.vc = e.vc + 16'd1;
            l = lfsr_step(l);
        end
        e.done_cyc = start_edge + n * (SETTLE + 1) + 1;
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest queued run
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifc.done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (cyc !== e.done_cyc) begin
                    errors++;
                    $display("FAIL done_latency: got cycle %0d, required %0d", cyc, e.done_cyc);
                end
                checks++;
                if (ifc.vec_cnt !== e.vc) begin
                    errors++;
                    $display("FAIL vec_cnt: got %0d, required %0d", ifc.vec_cnt, e.vc);
                end
                checks++;
                if (ifc.ones_cnt !== e.ones) begin
                    errors++;
                    $display("FAIL ones_cnt: got %0d, required %0d", ifc.ones_cnt, e.ones);
                end
                checks++;
                if (ifc.signature !== e.sig) begin
                    errors++;
                    $display("FAIL signature: got %h, required %h", ifc.signature, e.sig);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.start = 1'b0; ifc.abort = 1'b0; ifc.num_vec = '0; ifc.seed = '0;
        use_fn = 1'b0; const_out = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifc.dut_in, ifc.busy, ifc.done, ifc.vec_cnt, ifc.ones_cnt, ifc.signature} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: dut_in=%h busy=%b done=%b vec=%0d ones=%0d sig=%h, required all 0",
                     ifc.dut_in, ifc.busy, ifc.done, ifc.vec_cnt, ifc.ones_cnt, ifc.signature);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int busy_n = 0;
        use_fn = 1'b0; const_out = 1'b1;
        ifc.seed = '0; ifc.num_vec = 16'd1; ifc.start = 1'b1;
        sb_q.push_back('{vc: 16'd1, ones: 16'd1, sig: 16'h0001, done_cyc: cyc + 1 + 4});
        @(negedge clk);
        ifc.start = 1'b0;
        checks++;
        if (ifc.dut_in !== 42'h1) begin
            errors++;
            $display("FAIL single_dut_in: got %h, required %h", ifc.dut_in, 42'h1);
        end
        for (int i = 0; i < 6; i++) begin
            if (ifc.busy === 1'b1) busy_n++;
            @(negedge clk);
        end
        checks++;
        if (busy_n !== 3) begin
            errors++;
            $display("FAIL single_busy_cycles: got %0d, required 3", busy_n);
        end
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL single_drain: %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_three();
        logic [41:0] exp_vec [3];
        exp_vec[0] = 42'h1; exp_vec[1] = 42'h2; exp_vec[2] = 42'h4;
        use_fn = 1'b0; const_out = 1'b1;
        ifc.seed = 42'h1; ifc.num_vec = 16'd3; ifc.start = 1'b1;
        sb_q.push_back('{vc: 16'd3, ones: 16'd3, sig: 16'h0007, done_cyc: cyc + 1 + 10});
        @(negedge clk);
        ifc.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ifc.dut_in !== exp_vec[k]) begin
                errors++;
                $display("FAIL three_dut_in[%0d]: got %h, required %h", k, ifc.dut_in, exp_vec[k]);
            end
            repeat (3) @(negedge clk);
        end
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL three_drain: %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_zero();
        int busy_n = 0;
        ifc.seed = 42'h5; ifc.num_vec = 16'd0; ifc.start = 1'b1;
        sb_q.push_back('{vc: 16'd0, ones: 16'd0, sig: 16'h0000, done_cyc: cyc + 1 + 1});
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (ifc.busy === 1'b1) busy_n++;
            @(negedge clk);
        end
        checks++;
        if (busy_n !== 0) begin
            errors++;
            $display("FAIL zero_busy: busy high %0d cycles, required 0", busy_n);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL zero_drain: %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_abort();
        exp_t        part;
        logic [41:0] held;
        logic [41:0] s;
        s = 42'h0AB_CDEF_1234;
        use_fn = 1'b1;
        part = model_run(s, 6, 0);
        held = s;
        for (int i = 0; i < 6; i++) held = lfsr_step(held);
        ifc.seed = s; ifc.num_vec = 16'd100; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (19) @(negedge clk);
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        checks++;
        if (ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b, required 0", ifc.busy);
        end
        checks++;
        if (ifc.vec_cnt !== 16'd6 || ifc.ones_cnt !== part.ones || ifc.signature !== part.sig) begin
            errors++;
            $display("FAIL abort_hold: vec=%0d ones=%0d sig=%h, required vec=6 ones=%0d sig=%h",
                     ifc.vec_cnt, ifc.ones_cnt, ifc.signature, part.ones, part.sig);
        end
        checks++;
        if (ifc.dut_in !== held) begin
            errors++;
            $display("FAIL abort_dut_in: got %h, required %h", ifc.dut_in, held);
        end
        repeat (4) @(negedge clk);
        ifc.seed = 42'h3; ifc.num_vec = 16'd5; ifc.start = 1'b1;
        sb_q.push_back(model_run(42'h3, 5, cyc + 1));
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL abort_rerun_drain: %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_restart_ignored();
        int busy_n = 0;
        use_fn = 1'b1;
        ifc.seed = 42'h1_2345_6789; ifc.num_vec = 16'd4; ifc.start = 1'b1;
        sb_q.push_back(model_run(42'h1_2345_6789, 4, cyc + 1));
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i == 1 || i == 5 || i == 10) begin
                ifc.start = 1'b1; ifc.seed = 42'(i * 977 + 13); ifc.num_vec = 16'(i + 20);
            end else begin
                ifc.start = 1'b0;
            end
            @(negedge clk);
        end
        ifc.start = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL restart_drain: %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
        for (int i = 0; i < 5; i++) begin
            if (ifc.busy === 1'b1) busy_n++;
            @(negedge clk);
        end
        checks++;
        if (busy_n !== 0) begin
            errors++;
            $display("FAIL restart_extra_run: busy high %0d cycles, required 0", busy_n);
        end
    endtask

    task automatic test_back_to_back();
        use_fn = 1'b1;
        ifc.seed = 42'h2AA_AAAA_AAAA; ifc.num_vec = 16'd2; ifc.start = 1'b1;
        sb_q.push_back(model_run(42'h2AA_AAAA_AAAA, 2, cyc + 1));
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        ifc.seed = 42'h155_5555_5555; ifc.num_vec = 16'd3; ifc.start = 1'b1;
        sb_q.push_back(model_run(42'h155_5555_5555, 3, cyc + 1));
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset_midrun();
        int act_n = 0;
        use_fn = 1'b1;
        ifc.seed = 42'h3FF_0000_FFFF; ifc.num_vec = 16'd50; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ifc.dut_in, ifc.busy, ifc.done, ifc.vec_cnt, ifc.ones_cnt, ifc.signature} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: dut_in=%h busy=%b vec=%0d ones=%0d sig=%h, required all 0",
                     ifc.dut_in, ifc.busy, ifc.vec_cnt, ifc.ones_cnt, ifc.signature);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifc.busy === 1'b1 || ifc.done === 1'b1) act_n++;
        end
        checks++;
        if (act_n !== 0) begin
            errors++;
            $display("FAIL post_reset_idle: active %0d cycles, required 0", act_n);
        end
        ifc.seed = 42'h0DE_ADBE_EF01; ifc.num_vec = 16'd1000; ifc.start = 1'b1;
        sb_q.push_back(model_run(42'h0DE_ADBE_EF01, 1000, cyc + 1));
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i < 3100 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL long_run_drain: %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_three();
        test_zero();
        test_abort();
        test_restart_ignored();
        test_back_to_back();
        test_reset_midrun();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
